// File: rtl/ddr3_ref_sched.sv
// DDR3 refresh scheduler: tREFI interval timer, postponed-refresh debt tracking and REFRESH request handshake.
// Optional pull-in of refreshes ahead of schedule is enabled by defining DDR3_REF_PULLIN_EN.
`timescale 1ns/1ps
module ddr3_ref_sched #(
    parameter int DDR_FREQ_MHZ = 100,
    parameter int TREFI_NS     = 7800,
    parameter int MAX_POSTPONE = 8,
    parameter int URGENT_LEVEL = 6,
    parameter int MAX_PULLIN   = 8,
    parameter int DEBT_BITS    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cfg_run_i,
    input  logic                 ctl_idle_i,
    output logic                 ref_req_o,
    input  logic                 ref_rdy_i,
    output logic                 ref_urgent_o,
    output logic [DEBT_BITS-1:0] ref_debt_o,
    output logic                 ref_err_o
);
    localparam int TREFI_CYCLES = TREFI_NS * DDR_FREQ_MHZ / 1000;
    localparam int CNT_BITS     = $clog2(TREFI_CYCLES + 1);
    localparam logic [CNT_BITS-1:0]  CNT_RELOAD = CNT_BITS'(TREFI_CYCLES - 1);
    localparam logic [DEBT_BITS-1:0] MAX_DEBT   = DEBT_BITS'(MAX_POSTPONE);
    localparam logic [DEBT_BITS-1:0] URG_DEBT   = DEBT_BITS'(URGENT_LEVEL);
    localparam logic [DEBT_BITS-1:0] MAX_AHEAD  = DEBT_BITS'(MAX_PULLIN);
`ifdef DDR3_REF_PULLIN_EN
    localparam bit PULLIN_EN = 1'b1;
`else
    localparam bit PULLIN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_OFF, ST_WAIT, ST_REQ} state_t;

    state_t               state_reg, state_next;
    logic [CNT_BITS-1:0]  cnt_reg, cnt_next;
    logic [DEBT_BITS-1:0] debt_reg, debt_next;
    logic [DEBT_BITS-1:0] ahead_reg;
    logic                 req_reg, urgent_reg;
    logic                 err_reg, err_next;
    logic                 tick, hs, pullin_ok, issue;

`ifdef DDR3_REF_PULLIN_EN
    logic [DEBT_BITS-1:0] ahead_next;
`else
    assign ahead_reg = '0;
`endif

    assign tick      = (state_reg != ST_OFF) && (cnt_reg == '0);
    assign hs        = (state_reg == ST_REQ) && ref_rdy_i;
    assign pullin_ok = PULLIN_EN && (debt_reg == '0) && ctl_idle_i && (ahead_reg < MAX_AHEAD);
    // Issue decision looks at debt before this cycle's tick/handshake update.
    assign issue     = ((debt_reg != '0) && ctl_idle_i) || (debt_reg >= URG_DEBT) || pullin_ok;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        debt_next  = debt_reg;
        err_next   = err_reg;
`ifdef DDR3_REF_PULLIN_EN
        ahead_next = ahead_reg;
`endif
        if (!cfg_run_i) begin
            state_next = ST_OFF;
            cnt_next   = '0;
            debt_next  = '0;
            err_next   = 1'b0;
`ifdef DDR3_REF_PULLIN_EN
            ahead_next = '0;
`endif
        end else begin
            case (state_reg)
                ST_OFF: begin
                    state_next = ST_WAIT;
                    cnt_next   = CNT_RELOAD;
                    debt_next  = '0;
`ifdef DDR3_REF_PULLIN_EN
                    ahead_next = '0;
`endif
                end
                ST_WAIT, ST_REQ: begin
                    cnt_next = tick ? CNT_RELOAD : cnt_reg - 1'b1;
                    if (state_reg == ST_WAIT && issue)
                        state_next = ST_REQ;
                    else if (hs)
                        state_next = ST_WAIT;
                    // A tick coinciding with a handshake cancels out.
                    if (tick && !hs) begin
                        if (ahead_reg != '0) begin
`ifdef DDR3_REF_PULLIN_EN
                            ahead_next = ahead_reg - 1'b1;
`endif
                        end else if (debt_reg < MAX_DEBT) begin
                            debt_next = debt_reg + 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else if (hs && !tick) begin
                        if (debt_reg != '0) begin
                            debt_next = debt_reg - 1'b1;
                        end else begin
`ifdef DDR3_REF_PULLIN_EN
                            ahead_next = ahead_reg + 1'b1;
`endif
                        end
                    end
                end
                default: state_next = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_OFF;
            cnt_reg    <= '0;
            debt_reg   <= '0;
            req_reg    <= 1'b0;
            urgent_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            debt_reg   <= debt_next;
            req_reg    <= (state_next == ST_REQ);
            urgent_reg <= (debt_next >= URG_DEBT);
            err_reg    <= err_next;
        end
    end

`ifdef DDR3_REF_PULLIN_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ahead_reg <= '0;
        else       ahead_reg <= ahead_next;
    end
`endif

    assign ref_req_o    = req_reg;
    assign ref_urgent_o = urgent_reg;
    assign ref_debt_o   = debt_reg;
    assign ref_err_o    = err_reg;
endmodule

// File: tb/tb_ddr3_ref_sched.sv
// Directed bench for ddr3_ref_sched at default parameters (tREFI = 780 cycles).
// Edge counts are relative to E0, the first edge that samples cfg_run_i high.
`timescale 1ns/1ps
module tb_ddr3_ref_sched;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_run_i = 1'b0;
    logic       ctl_idle_i = 1'b0;
    logic       ref_req_o;
    logic       ref_rdy_i = 1'b0;
    logic       ref_urgent_o;
    logic [3:0] ref_debt_o;
    logic       ref_err_o;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int cyc0 = 0;

    ddr3_ref_sched dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_run_i   (cfg_run_i),
        .ctl_idle_i  (ctl_idle_i),
        .ref_req_o   (ref_req_o),
        .ref_rdy_i   (ref_rdy_i),
        .ref_urgent_o(ref_urgent_o),
        .ref_debt_o  (ref_debt_o),
        .ref_err_o   (ref_err_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc - cyc0);
        end else begin
            $display("ok   %s: %0d (edge %0d)", tag, got, cyc - cyc0);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Advance until the last edge passed is E<k>.
    task automatic goto_edge(input int k);
        while (cyc - cyc0 < k) step();
    endtask

    task automatic restart(input logic idle, input logic rdy);
        cfg_run_i = 1'b0;
        step();
        ctl_idle_i = idle;
        ref_rdy_i  = rdy;
        cfg_run_i  = 1'b1;
        step();
        cyc0 = cyc;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    initial begin
        int n;
        int c1;
        int reqs;

        // Reset state
        repeat (3) step();
        check("rst_req", ref_req_o, 0);
        check("rst_urgent", ref_urgent_o, 0);
        check("rst_debt", ref_debt_o, 0);
        check("rst_err", ref_err_o, 0);
        reset = 1'b0;
        step();

        // Idle controller, always ready: first request 781 edges after E0, period 780
        restart(1'b1, 1'b1);
        n = 0;
        while (!ref_req_o && n < 2000) begin
            step();
            n++;
        end
        check("first_req_latency", n, 781);
        c1 = cyc;
        step();
        check("hs_req_drop", ref_req_o, 0);
        check("hs_debt_zero", ref_debt_o, 0);
        n = 0;
        while (!ref_req_o && n < 2000) begin
            step();
            n++;
        end
        check("req_period", cyc - c1, 780);

        // Busy controller: debt climbs to urgency, request forced, one handshake drains to 5
        restart(1'b0, 1'b0);
        goto_edge(3900);
        check("busy_debt5", ref_debt_o, 5);
        check("busy_urgent_at5", ref_urgent_o, 0);
        check("busy_no_req_at5", ref_req_o, 0);
        goto_edge(4679);
        check("busy_debt_before6", ref_debt_o, 5);
        goto_edge(4680);
        check("busy_debt6", ref_debt_o, 6);
        check("busy_urgent_at6", ref_urgent_o, 1);
        check("busy_req_not_yet", ref_req_o, 0);
        step();
        check("urgent_req_forced", ref_req_o, 1);
        ref_rdy_i = 1'b1;
        step();
        ref_rdy_i = 1'b0;
        check("drain_debt5", ref_debt_o, 5);
        check("drain_urgent_clear", ref_urgent_o, 0);
        check("drain_req_drop", ref_req_o, 0);
        step();
        check("drain_no_new_req", ref_req_o, 0);

        // Never ready: debt saturates at 8, ninth tick sets the sticky error
        restart(1'b0, 1'b0);
        goto_edge(6240);
        check("sat_debt8", ref_debt_o, 8);
        check("sat_err_before", ref_err_o, 0);
        goto_edge(7019);
        check("sat_err_pre_tick9", ref_err_o, 0);
        goto_edge(7020);
        check("sat_err_tick9", ref_err_o, 1);
        check("sat_debt_held", ref_debt_o, 8);
        goto_edge(7800);
        check("sat_err_sticky", ref_err_o, 1);
        check("sat_req_held", ref_req_o, 1);
        cfg_run_i = 1'b0;
        step();
        check("off_err_clear", ref_err_o, 0);
        check("off_debt_clear", ref_debt_o, 0);
        check("off_urgent_clear", ref_urgent_o, 0);
        check("off_req_clear", ref_req_o, 0);

        // Tick and handshake in the same cycle at debt 3
        restart(1'b0, 1'b0);
        goto_edge(2340);
        check("coinc_debt3", ref_debt_o, 3);
        ctl_idle_i = 1'b1;
        step();
        check("coinc_req_idle", ref_req_o, 1);
        goto_edge(3119);
        check("coinc_req_held", ref_req_o, 1);
        ref_rdy_i = 1'b1;
        step();
        ref_rdy_i = 1'b0;
        check("coinc_debt_kept", ref_debt_o, 3);
        check("coinc_req_drop", ref_req_o, 0);

        // cfg_run_i dropped while requesting at debt 4, then restart timing
        restart(1'b0, 1'b0);
        goto_edge(3120);
        check("drop_debt4", ref_debt_o, 4);
        ctl_idle_i = 1'b1;
        step();
        check("drop_req_up", ref_req_o, 1);
        cfg_run_i = 1'b0;
        step();
        check("drop_req_clear", ref_req_o, 0);
        check("drop_debt_clear", ref_debt_o, 0);
        check("drop_err_clear", ref_err_o, 0);
        ctl_idle_i = 1'b0;
        cfg_run_i  = 1'b1;
        step();
        cyc0 = cyc;
        goto_edge(779);
        check("rerun_pre_tick", ref_debt_o, 0);
        goto_edge(780);
        check("rerun_first_tick", ref_debt_o, 1);

`ifdef DDR3_REF_PULLIN_EN
        // Pull-in: eight early refreshes, then ticks consume them before debt accrues
        restart(1'b1, 1'b1);
        reqs = 0;
        while (cyc - cyc0 < 700) begin
            step();
            if (ref_req_o) reqs++;
        end
        check("pullin_count", reqs, 8);
        ctl_idle_i = 1'b0;
        while (cyc - cyc0 < 6240) begin
            step();
            if (ref_req_o) reqs++;
        end
        check("pullin_debt_after8", ref_debt_o, 0);
        check("pullin_no_more_req", reqs, 8);
        goto_edge(7020);
        check("pullin_debt_tick9", ref_debt_o, 1);
`else
        reqs = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
